// File: rtl/uart_dbg_pkg.sv
// Package: uart_dbg_pkg
// Shared command/response byte codes and the controller state encoding for the
// uart debug sequencer (uart_debug_ctrl and uart_dbg_tx_ser).
package uart_dbg_pkg;

    // Host command bytes, decoded in IDLE
    localparam logic [7:0] CmdLoad = 8'h01;
    localparam logic [7:0] CmdRun  = 8'h02;
    localparam logic [7:0] CmdStep = 8'h03;
    localparam logic [7:0] CmdDump = 8'h04;

    // Response bytes
    localparam logic [7:0] AckLoad = 8'hA1;
    localparam logic [7:0] AckRun  = 8'hA2;
    localparam logic [7:0] AckStep = 8'hA3;
    localparam logic [7:0] AckDump = 8'hA4;
    localparam logic [7:0] ErrByte = 8'hEE;

    typedef enum logic [3:0] {
        StIdle,
        StLdLen,
        StLdByte,
        StLdWr,
        StRun,
        StStep,
        StDmpRd,
        StDmpCap,
        StDmpTx,
        StSend,
        StErr
    } state_e;

endpackage

// File: rtl/uart_dbg_tx_ser.sv
// Module: uart_dbg_tx_ser
// Splits one word into NB_WORD/NB_DATA bytes, least-significant byte first, and
// pushes them into the uart TX FIFO, stalling while the FIFO reports full.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_start          load i_word and begin sending (ignored while busy)
//   i_word           word to serialise
//   i_tx_full        TX FIFO full; no push while high
//   o_wr, o_data     TX FIFO push strobe and byte
//   o_busy           a word is being sent
//   o_done           high in the cycle the last byte is pushed
module uart_dbg_tx_ser #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_WORD = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_tx_full,
    output logic               o_wr,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned NbBytes = NB_WORD / NB_DATA;
    localparam int unsigned IdxW    = (NbBytes > 1) ? $clog2(NbBytes) : 1;

    logic               active_q, active_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [NB_WORD-1:0] word_q, word_d;
    logic               last;

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        word_d   = word_q;
        last     = (idx_q == IdxW'(NbBytes - 1));
        o_wr     = active_q && !i_tx_full;
        o_data   = word_q[idx_q*NB_DATA +: NB_DATA];
        o_busy   = active_q;
        o_done   = o_wr && last;

        if (!active_q) begin
            if (i_start) begin
                active_d = 1'b1;
                idx_d    = '0;
                word_d   = i_word;
            end
        end else if (o_wr) begin
            if (last) begin
                active_d = 1'b0;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            word_q   <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
        end
    end

endmodule

// File: rtl/uart_debug_ctrl.sv
// Module: uart_debug_ctrl
// Command sequencer between the uart RX/TX FIFOs and the MIPS core: loads
// program words into imem, runs/steps the core and dumps the register file.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_rx_empty, i_rx_data     RX FIFO status and head byte (first-word-fall-through)
//   o_rd_uart                 RX FIFO pop, one byte per high cycle
//   i_tx_full                 TX FIFO full
//   o_wr_uart, o_tx_data      TX FIFO push strobe and byte
//   o_imem_we/addr/data       instruction memory write port
//   o_run, o_step, i_halt     core run level, single-step pulse, halt status
//   o_dbg_addr, i_dbg_data    register-file debug read (data one cycle later)
//   o_busy                    high whenever not idle
module uart_debug_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_WORD = 32,
    parameter int unsigned NB_ADDR = 10,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned TIMEOUT = 500000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic               o_rd_uart,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_WORD-1:0] o_imem_data,
    output logic               o_run,
    output logic               o_step,
    input  logic               i_halt,
    output logic [NB_REG-1:0]  o_dbg_addr,
    input  logic [NB_WORD-1:0] i_dbg_data,
    output logic               o_busy
);

    localparam int unsigned NbBytes = NB_WORD / NB_DATA;
    localparam int unsigned KW      = (NbBytes > 1) ? $clog2(NbBytes) : 1;
    localparam int unsigned CntW    = NB_DATA + 1;  // holds 2**NB_DATA words
    localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [NB_DATA-1:0] send_q, send_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [KW-1:0]      k_q, k_d;
    logic [NB_WORD-1:0] word_q, word_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic [NB_REG-1:0]  reg_q, reg_d;

    logic               rx_ok, tmo_hit, send_wr;
    logic               ser_start, ser_wr, ser_busy, ser_done;
    logic [NB_DATA-1:0] ser_data;

    assign rx_ok   = !i_rx_empty;
    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        send_d    = send_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        word_d    = word_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        reg_d     = reg_q;
        o_rd_uart = 1'b0;
        o_imem_we = 1'b0;
        o_run     = 1'b0;
        o_step    = 1'b0;
        send_wr   = 1'b0;
        ser_start = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_ok) begin
                    o_rd_uart = 1'b1;
                    ret_d     = StIdle;
                    if (i_rx_data == NB_DATA'(CmdLoad)) begin
                        addr_d  = '0;
                        tmo_d   = '0;
                        state_d = StLdLen;
                    end else if (i_rx_data == NB_DATA'(CmdRun)) begin
                        if (i_halt) begin
                            send_d  = NB_DATA'(AckRun);
                            state_d = StSend;
                        end else begin
                            state_d = StRun;
                        end
                    end else if (i_rx_data == NB_DATA'(CmdStep)) begin
                        state_d = StStep;
                    end else if (i_rx_data == NB_DATA'(CmdDump)) begin
                        reg_d   = '0;
                        state_d = StDmpRd;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StLdLen: begin
                if (rx_ok) begin
                    o_rd_uart = 1'b1;
                    // A length byte of zero means the full 2**NB_DATA words
                    cnt_d     = (i_rx_data == '0) ? CntW'(2 ** NB_DATA) : CntW'(i_rx_data);
                    k_d       = '0;
                    tmo_d     = '0;
                    state_d   = StLdByte;
                end else if (tmo_hit) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StLdByte: begin
                if (rx_ok) begin
                    o_rd_uart                   = 1'b1;
                    word_d[k_q*NB_DATA +: NB_DATA] = i_rx_data;
                    tmo_d                       = '0;
                    if (k_q == KW'(NbBytes - 1)) begin
                        k_d     = '0;
                        state_d = StLdWr;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    // Partial word is simply dropped; nothing reaches imem
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StLdWr: begin
                o_imem_we = 1'b1;
                addr_d    = addr_q + 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    send_d  = NB_DATA'(AckLoad);
                    ret_d   = StIdle;
                    state_d = StSend;
                end else begin
                    state_d = StLdByte;
                end
            end
            StRun: begin
                // Held for the whole state so it falls on the edge halt is sampled
                o_run = 1'b1;
                if (i_halt) begin
                    send_d  = NB_DATA'(AckRun);
                    ret_d   = StIdle;
                    state_d = StSend;
                end
            end
            StStep: begin
                o_step  = 1'b1;
                send_d  = NB_DATA'(AckStep);
                ret_d   = StIdle;
                state_d = StSend;
            end
            StDmpRd: begin
                state_d = StDmpCap;
            end
            StDmpCap: begin
                ser_start = 1'b1;
                state_d   = StDmpTx;
            end
            StDmpTx: begin
                if (ser_done) begin
                    if (reg_q == {NB_REG{1'b1}}) begin
                        send_d  = NB_DATA'(AckDump);
                        ret_d   = StIdle;
                        state_d = StSend;
                    end else begin
                        reg_d   = reg_q + 1'b1;
                        state_d = StDmpRd;
                    end
                end
            end
            StSend: begin
                if (!i_tx_full) begin
                    send_wr = 1'b1;
                    state_d = ret_q;
                end
            end
            StErr: begin
                send_d  = NB_DATA'(ErrByte);
                ret_d   = StIdle;
                state_d = StSend;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            ret_q   <= StIdle;
            send_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            tmo_q   <= '0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            send_q  <= send_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            reg_q   <= reg_d;
        end
    end

    uart_dbg_tx_ser #(
        .NB_DATA (NB_DATA),
        .NB_WORD (NB_WORD)
    ) u_tx_ser (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (ser_start),
        .i_word    (i_dbg_data),
        .i_tx_full (i_tx_full),
        .o_wr      (ser_wr),
        .o_data    (ser_data),
        .o_busy    (ser_busy),
        .o_done    (ser_done)
    );

    // SEND and the serialiser are never active together
    assign o_wr_uart   = send_wr | ser_wr;
    assign o_tx_data   = ser_busy ? ser_data : send_q;
    assign o_imem_addr = addr_q;
    assign o_imem_data = word_q;
    assign o_dbg_addr  = reg_q;
    assign o_busy      = (state_q != StIdle);

endmodule
